branch_pred_btb: RTL

Fetch-side branch predictor: a direct-mapped branch target buffer with per-entry 2-bit saturating counters. It answers fetch-PC lookups with a taken/target prediction one cycle later. Execute trains it with resolved branch and jump outcomes. It produces the branch-prediction hint and predicted target that execute later checks and, on mismatch, redirects fetch away from.

---
 rtl/branch_pred_btb_pkg.sv | 29 ++
 rtl/branch_pred_btb_if.sv | 28 ++
 rtl/branch_pred_btb_tag_match.sv | 16 +
 rtl/branch_pred_btb.sv | 130 +++++++++++++
 4 files changed

// File: rtl/branch_pred_btb_pkg.sv
// Shared definitions for the fetch-side branch target buffer: counter
// encoding, saturating counter step and the update-action decode type.
package branch_pred_btb_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t BP_SNT = 2'd0;
  localparam bp_cnt_t BP_WNT = 2'd1;
  localparam bp_cnt_t BP_WT  = 2'd2;
  localparam bp_cnt_t BP_ST  = 2'd3;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_HIT,
    UPD_ALLOC
  } upd_kind_e;

  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BP_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BP_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pred_btb_if.sv
// Lookup / prediction / training bundle between fetch, execute and the BTB.
interface branch_pred_btb_if #(
  parameter int IADDR_SPACE_BITS = 16
);
  logic                          i_flush;
  logic                          i_lookup_valid;
  logic [IADDR_SPACE_BITS-1:1]   i_lookup_pc;
  logic                          o_pred_valid;
  logic                          o_pred_taken;
  logic [IADDR_SPACE_BITS-1:1]   o_pred_target;
  logic                          i_upd_valid;
  logic [IADDR_SPACE_BITS-1:1]   i_upd_pc;
  logic [IADDR_SPACE_BITS-1:1]   i_upd_target;
  logic                          i_upd_taken;
  logic                          i_upd_jump;

  modport slave (
    input  i_flush, i_lookup_valid, i_lookup_pc,
    input  i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken, i_upd_jump,
    output o_pred_valid, o_pred_taken, o_pred_target
  );

  modport master (
    output i_flush, i_lookup_valid, i_lookup_pc,
    output i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken, i_upd_jump,
    input  o_pred_valid, o_pred_taken, o_pred_target
  );
endinterface

// File: rtl/branch_pred_btb_tag_match.sv
// Combinational hit detect for one port of the direct-mapped BTB.
module btb_tag_match #(
  parameter int ENTRIES  = 8,
  parameter int IDX_BITS = 3,
  parameter int TAG_W    = 12
) (
  input  logic [IDX_BITS-1:0]             i_idx,
  input  logic [TAG_W-1:0]                i_tag,
  input  logic [ENTRIES-1:0]              i_valid,
  input  logic [ENTRIES-1:0][TAG_W-1:0]   i_tags,
  output logic                            o_hit
);

  assign o_hit = i_valid[i_idx] & (i_tags[i_idx] == i_tag);

endmodule

// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters;
// one-cycle lookup, trained by resolved branches/jumps from execute.
module branch_pred_btb
  import branch_pred_btb_pkg::*;
#(
  parameter int IADDR_SPACE_BITS  = 16,
  parameter int BTB_ENTRIES       = 8,
  parameter int BRANCH_PREDICTION = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  branch_pred_btb_if.slave bus
);

  localparam int  IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int  PC_W     = IADDR_SPACE_BITS - 1;
  localparam int  TAG_W    = PC_W - IDX_BITS;
  localparam bit  PRED_EN  = (BRANCH_PREDICTION != 0);

  logic [BTB_ENTRIES-1:0]             r_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  r_tag;
  logic [BTB_ENTRIES-1:0][PC_W-1:0]   r_target;
  bp_cnt_t [BTB_ENTRIES-1:0]          r_cnt;

  logic                               r_vld_p1;
  logic                               r_taken_p1;
  logic [PC_W-1:0]                    r_target_p1;

  logic [IDX_BITS-1:0]                w_lk_idx;
  logic [TAG_W-1:0]                   w_lk_tag;
  logic                               w_lk_hit;
  logic                               w_lk_vld;
  logic                               w_lk_taken;

  logic [IDX_BITS-1:0]                w_upd_idx;
  logic [TAG_W-1:0]                   w_upd_tag;
  logic                               w_upd_hit;
  upd_kind_e                          w_upd_kind;
  bp_cnt_t                            w_cnt_new;
  logic                               w_tgt_wr;

  assign w_lk_idx  = bus.i_lookup_pc[IDX_BITS:1];
  assign w_lk_tag  = bus.i_lookup_pc[IADDR_SPACE_BITS-1:IDX_BITS+1];
  assign w_upd_idx = bus.i_upd_pc[IDX_BITS:1];
  assign w_upd_tag = bus.i_upd_pc[IADDR_SPACE_BITS-1:IDX_BITS+1];

  btb_tag_match #(
    .ENTRIES  (BTB_ENTRIES),
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_lk_match (
    .i_idx   (w_lk_idx),
    .i_tag   (w_lk_tag),
    .i_valid (r_valid),
    .i_tags  (r_tag),
    .o_hit   (w_lk_hit)
  );

  btb_tag_match #(
    .ENTRIES  (BTB_ENTRIES),
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_upd_match (
    .i_idx   (w_upd_idx),
    .i_tag   (w_upd_tag),
    .i_valid (r_valid),
    .i_tags  (r_tag),
    .o_hit   (w_upd_hit)
  );

  // Lookup reads pre-update array contents: no bypass from the update port.
  assign w_lk_vld   = bus.i_lookup_valid & ~bus.i_flush;
  assign w_lk_taken = w_lk_hit & r_cnt[w_lk_idx][1] & PRED_EN;

  always_comb begin
    w_upd_kind = UPD_NONE;
    w_cnt_new  = r_cnt[w_upd_idx];
    w_tgt_wr   = 1'b0;
    if (bus.i_upd_valid) begin
      if (w_upd_hit) begin
        w_upd_kind = UPD_HIT;
        w_cnt_new  = bus.i_upd_jump ? BP_ST : bp_cnt_next(r_cnt[w_upd_idx], bus.i_upd_taken);
        w_tgt_wr   = bus.i_upd_jump | bus.i_upd_taken;
      end else if (bus.i_upd_taken && PRED_EN) begin
        w_upd_kind = UPD_ALLOC;
        w_cnt_new  = bus.i_upd_jump ? BP_ST : BP_WT;
        w_tgt_wr   = 1'b1;
      end
    end
  end

  // Only valid bits need clearing; stale tag/target/counter are masked by valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      case (w_upd_kind)
        UPD_HIT: begin
          r_cnt[w_upd_idx] <= w_cnt_new;
          if (w_tgt_wr) r_target[w_upd_idx] <= bus.i_upd_target;
        end
        UPD_ALLOC: begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= bus.i_upd_target;
          r_cnt[w_upd_idx]    <= w_cnt_new;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p0 -> p1: registered prediction ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_p1    <= 1'b0;
      r_taken_p1  <= 1'b0;
      r_target_p1 <= '0;
    end else begin
      r_vld_p1    <= w_lk_vld;
      r_taken_p1  <= w_lk_vld & w_lk_taken;
      r_target_p1 <= (w_lk_vld & w_lk_taken) ? r_target[w_lk_idx] : '0;
    end
  end

  assign bus.o_pred_valid  = r_vld_p1;
  assign bus.o_pred_taken  = r_taken_p1;
  assign bus.o_pred_target = r_target_p1;

endmodule
